// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions: datapath width default, ALU func3 codes,
// requester id width and the output-slot state encoding.
package riscv_pkg;

    localparam int XLEN_DEFAULT = 32;
    localparam int ID_W         = 1;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } slot_state_e;

endpackage

// File: rtl/alu_arb_grant2.sv
// Two-way grant logic. With ALU_ARB_RR_EN defined it is round-robin with a
// last-winner pointer; otherwise requester 0 has fixed priority.
module alu_arb_grant2 (
`ifdef ALU_ARB_RR_EN
    input  logic clk,
    input  logic rst,
`endif
    input  logic valid0_i,
    input  logic valid1_i,
    input  logic en_i,
    output logic grant0_o,
    output logic grant1_o
);

`ifdef ALU_ARB_RR_EN
    logic last_q, last_d;

    // NOTE: sequential state is written with non-blocking assignments so
    // every register samples the pre-edge values of its inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

    // A tie goes to the requester that did not win last time.
    always_comb begin
        grant0_o = en_i && valid0_i && (!valid1_i || last_q);
        grant1_o = en_i && valid1_i && (!valid0_i || !last_q);
        last_d   = last_q;
        if (grant0_o) begin
            last_d = 1'b0;
        end else if (grant1_o) begin
            last_d = 1'b1;
        end
    end
`else
    assign grant0_o = en_i && valid0_i;
    assign grant1_o = en_i && valid1_i && !valid0_i;
`endif

endmodule

// File: rtl/alu_riscv.sv
// Combinational RV32I-style integer ALU: func3 selects the operation,
// opequal selects SUB over ADD and SRA over SRL.
module alu_riscv
    import riscv_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic [XLEN-1:0] in1_i,
    input  logic [XLEN-1:0] in2_i,
    input  logic [2:0]      func3_i,
    input  logic            opequal_i,
    output logic [XLEN-1:0] alu_o
);

    localparam int SHW = $clog2(XLEN);

    logic [SHW-1:0]         shamt;
    logic signed [XLEN-1:0] sra_res;

    assign shamt = in2_i[SHW-1:0];
    // Kept apart from the result mux: inside a ternary with unsigned operands
    // the shift would lose its signedness and become logical.
    assign sra_res = $signed(in1_i) >>> shamt;

    always_comb begin
        // NOTE: assign a default before the case so no path leaves the
        // output unassigned, which would infer a latch.
        alu_o = in1_i & in2_i;
        case (func3_i)
            F3_ADD:  alu_o = opequal_i ? (in1_i - in2_i) : (in1_i + in2_i);
            F3_SLL:  alu_o = in1_i << shamt;
            F3_SLT:  alu_o = {{(XLEN-1){1'b0}}, ($signed(in1_i) < $signed(in2_i))};
            F3_SLTU: alu_o = {{(XLEN-1){1'b0}}, (in1_i < in2_i)};
            F3_XOR:  alu_o = in1_i ^ in2_i;
            F3_SR:   alu_o = opequal_i ? $unsigned(sra_res) : (in1_i >> shamt);
            F3_OR:   alu_o = in1_i | in2_i;
            default: alu_o = in1_i & in2_i;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one alu_riscv between two valid/ready requesters and returns results
// through a single registered, id-tagged slot. Macro ALU_ARB_RR_EN selects
// round-robin arbitration; the default build is fixed priority to requester 0.
module alu_arbiter
    import riscv_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [XLEN-1:0] req0_in1,
    input  logic [XLEN-1:0] req0_in2,
    input  logic [2:0]      req0_func3,
    input  logic            req0_opequal,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [XLEN-1:0] req1_in1,
    input  logic [XLEN-1:0] req1_in2,
    input  logic [2:0]      req1_func3,
    input  logic            req1_opequal,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic            rsp_id,
    output logic [XLEN-1:0] rsp_data
);

    slot_state_e     state_q, state_d;
    logic [ID_W-1:0] rsp_id_q, rsp_id_d;
    logic [XLEN-1:0] rsp_data_q, rsp_data_d;

    logic            slot_free;
    logic            grant_en;
    logic            grant0, grant1, grant_any;
    logic [XLEN-1:0] alu_in1, alu_in2, alu_out;
    logic [2:0]      alu_func3;
    logic            alu_opequal;

    // The slot counts as free while it drains, so back-to-back grants need no bubble.
    assign slot_free = (state_q == ST_EMPTY) || rsp_ready;
    assign grant_en  = slot_free && !rst;
    assign grant_any = grant0 || grant1;

    alu_arb_grant2 u_grant (
`ifdef ALU_ARB_RR_EN
        .clk      (clk),
        .rst      (rst),
`endif
        .valid0_i (req0_valid),
        .valid1_i (req1_valid),
        .en_i     (grant_en),
        .grant0_o (grant0),
        .grant1_o (grant1)
    );

    assign alu_in1     = grant1 ? req1_in1     : req0_in1;
    assign alu_in2     = grant1 ? req1_in2     : req0_in2;
    assign alu_func3   = grant1 ? req1_func3   : req0_func3;
    assign alu_opequal = grant1 ? req1_opequal : req0_opequal;

    alu_riscv #(.XLEN(XLEN)) u_alu (
        .in1_i     (alu_in1),
        .in2_i     (alu_in2),
        .func3_i   (alu_func3),
        .opequal_i (alu_opequal),
        .alu_o     (alu_out)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_EMPTY;
            rsp_id_q   <= '0;
            rsp_data_q <= '0;
        end else begin
            state_q    <= state_d;
            rsp_id_q   <= rsp_id_d;
            rsp_data_q <= rsp_data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (grant_any) state_d = ST_FULL;
            ST_FULL:  if (!grant_any && rsp_ready) state_d = ST_EMPTY;
            default:  state_d = ST_EMPTY;
        endcase
    end

    // Id and data hold their last values once drained.
    always_comb begin
        rsp_id_d   = rsp_id_q;
        rsp_data_d = rsp_data_q;
        if (grant_any) begin
            rsp_id_d   = grant1;
            rsp_data_d = alu_out;
        end
    end

    always_comb begin
        rsp_valid  = (state_q == ST_FULL);
        rsp_id     = rsp_id_q;
        rsp_data   = rsp_data_q;
        req0_ready = grant0;
        req1_ready = grant1;
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus constrained
// random traffic, checked by a reference model and an id/data scoreboard.
module tb_alu_arbiter;
    import riscv_pkg::*;

    localparam int XLEN = 32;

    logic            clk, rst;
    logic            req0_valid, req0_ready, req0_opequal;
    logic [XLEN-1:0] req0_in1, req0_in2;
    logic [2:0]      req0_func3;
    logic            req1_valid, req1_ready, req1_opequal;
    logic [XLEN-1:0] req1_in1, req1_in2;
    logic [2:0]      req1_func3;
    logic            rsp_valid, rsp_ready, rsp_id;
    logic [XLEN-1:0] rsp_data;

    alu_arbiter #(.XLEN(XLEN)) dut (
        .clk          (clk),
        .rst          (rst),
        .req0_valid   (req0_valid),
        .req0_ready   (req0_ready),
        .req0_in1     (req0_in1),
        .req0_in2     (req0_in2),
        .req0_func3   (req0_func3),
        .req0_opequal (req0_opequal),
        .req1_valid   (req1_valid),
        .req1_ready   (req1_ready),
        .req1_in1     (req1_in1),
        .req1_in2     (req1_in2),
        .req1_func3   (req1_func3),
        .req1_opequal (req1_opequal),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_id       (rsp_id),
        .rsp_data     (rsp_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic            id;
        logic [XLEN-1:0] data;
    } rsp_t;

    rsp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference ALU on plain integer arithmetic.
    function automatic logic [XLEN-1:0] alu_ref(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                                 input logic [2:0] f, input logic oe);
        int          sa, sb_v;
        int unsigned sh;
        sa   = int'(a);
        sb_v = int'(b);
        sh   = int'(b) & 31;
        case (f)
            3'd0:    return oe ? a - b : a + b;
            3'd1:    return a << sh;
            3'd2:    return (sa < sb_v) ? 32'd1 : 32'd0;
            3'd3:    return (a < b) ? 32'd1 : 32'd0;
            3'd4:    return a ^ b;
            3'd5:    return oe ? 32'(sa >>> sh) : a >> sh;
            3'd6:    return a | b;
            default: return a & b;
        endcase
    endfunction

    // Reference model: arbitration policy and slot occupancy, evaluated on the falling edge.
    logic m_full, m_last, e0, e1, m_free;
    rsp_t m_cur, m_item;

    always @(negedge clk) begin
        if (rst) begin
            m_full = 1'b0;
            m_last = 1'b1;
            sb.delete();
        end else begin
            m_free = !m_full || rsp_ready;
            e0 = 1'b0;
            e1 = 1'b0;
            if (m_free) begin
`ifdef ALU_ARB_RR_EN
                if (req0_valid && req1_valid) begin
                    e0 = m_last;
                    e1 = !m_last;
                end else begin
                    e0 = req0_valid;
                    e1 = req1_valid;
                end
`else
                e0 = req0_valid;
                e1 = req1_valid && !req0_valid;
`endif
            end
            check("req0_ready", req0_ready, e0);
            check("req1_ready", req1_ready, e1);
            check("rsp_valid", rsp_valid, m_full);
            if (m_full) begin
                check("slot_id", rsp_id, m_cur.id);
                check("slot_data", rsp_data, m_cur.data);
            end
            if (e0 || e1) begin
                m_item.id   = e1;
                m_item.data = e1 ? alu_ref(req1_in1, req1_in2, req1_func3, req1_opequal)
                                 : alu_ref(req0_in1, req0_in2, req0_func3, req0_opequal);
                sb.push_back(m_item);
                m_cur  = m_item;
                m_last = e1;
            end
            m_full = e0 || e1 || (m_full && !rsp_ready);
        end
    end

    // Monitor: every consumed response must match the oldest expected one.
    rsp_t mon_exp;
    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: got id %0d data 0x%0h expected no response", rsp_id, rsp_data);
            end else begin
                mon_exp = sb.pop_front();
                check("rsp_id", rsp_id, mon_exp.id);
                check("rsp_data", rsp_data, mon_exp.data);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set0(input logic v, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                        input logic [2:0] f, input logic oe);
        req0_valid = v; req0_in1 = a; req0_in2 = b; req0_func3 = f; req0_opequal = oe;
    endtask

    task automatic set1(input logic v, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                        input logic [2:0] f, input logic oe);
        req1_valid = v; req1_in1 = a; req1_in2 = b; req1_func3 = f; req1_opequal = oe;
    endtask

    logic [XLEN-1:0] seq_exp [4];
    logic            seq_id  [4];
    logic [XLEN-1:0] bp_exp;
    logic            a0, a1;

    initial begin
`ifdef ALU_ARB_RR_EN
        seq_exp = '{32'd11, 32'd1, 32'd11, 32'd1};
        seq_id  = '{1'b0, 1'b1, 1'b0, 1'b1};
        bp_exp  = 32'd5;
`else
        seq_exp = '{32'd11, 32'd11, 32'd11, 32'd11};
        seq_id  = '{1'b0, 1'b0, 1'b0, 1'b0};
        bp_exp  = 32'd23;
`endif
        rst = 1'b1;
        rsp_ready = 1'b1;
        set0(1'b1, 32'd6, 32'd5, 3'd0, 1'b0);
        set1(1'b1, 32'd6, 32'd5, 3'd0, 1'b1);
        repeat (2) step();
        check("reset_rsp_valid", rsp_valid, 1'b0);
        check("reset_rsp_id", rsp_id, 1'b0);
        check("reset_rsp_data", rsp_data, 32'd0);
        check("reset_req0_ready", req0_ready, 1'b0);
        check("reset_req1_ready", req1_ready, 1'b0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rst = 1'b0;

        // Both requesters valid every cycle.
        set0(1'b1, 32'd6, 32'd5, 3'd0, 1'b0);
        set1(1'b1, 32'd6, 32'd5, 3'd0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step();
            check("tie_data", rsp_data, seq_exp[i]);
            check("tie_id", rsp_id, seq_id[i]);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        step();

        // Single request: accepted the same cycle, result one cycle later.
        set0(1'b1, 32'd6, 32'd5, 3'd0, 1'b0);
        #1 check("single_ready", req0_ready, 1'b1);
        step();
        check("single_valid", rsp_valid, 1'b1);
        check("single_id", rsp_id, 1'b0);
        check("single_data", rsp_data, 32'd11);
        req0_valid = 1'b0;

        // Backpressure: slot stays stable and nothing is granted.
        rsp_ready = 1'b0;
        set0(1'b1, 32'd20, 32'd3, 3'd0, 1'b0);
        set1(1'b1, 32'd9, 32'd4, 3'd0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_data", rsp_data, 32'd11);
            check("stall_valid", rsp_valid, 1'b1);
            check("stall_readies", {req0_ready, req1_ready}, 2'b00);
        end
        rsp_ready = 1'b1;
        #1 check("drain_grant", req0_ready || req1_ready, 1'b1);
        step();
        check("no_bubble_valid", rsp_valid, 1'b1);
        check("no_bubble_data", rsp_data, bp_exp);

        // Reset mid-operation discards the pending result at once.
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready = 1'b0;
        #2 rst = 1'b1;
        set0(1'b1, 32'd20, 32'd3, 3'd0, 1'b0);
        set1(1'b1, 32'd9, 32'd4, 3'd0, 1'b1);
        #1;
        check("midrst_valid", rsp_valid, 1'b0);
        check("midrst_readies", {req0_ready, req1_ready}, 2'b00);
        step();
        step();
        rst = 1'b0;
        #1;
        check("post_rst_req0_ready", req0_ready, 1'b1);
        check("post_rst_req1_ready", req1_ready, 1'b0);
        step();
        check("post_rst_id", rsp_id, 1'b0);
        check("post_rst_data", rsp_data, 32'd23);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready = 1'b1;

        // Function sweep on requester 1.
        for (int oe = 0; oe < 2; oe++) begin
            for (int f = 0; f < 8; f++) begin
                set1(1'b1, 32'd6, 32'd5, 3'(f), 1'(oe));
                step();
                check("sweep_id", rsp_id, 1'b1);
                check("sweep_data", rsp_data, alu_ref(32'd6, 32'd5, 3'(f), 1'(oe)));
            end
        end
        req1_valid = 1'b0;
        step();

        // Random traffic; a requester changes its request only once accepted.
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            a0 = req0_valid && req0_ready;
            a1 = req1_valid && req1_ready;
            @(posedge clk);
            #1;
            if (!req0_valid || a0)
                set0($urandom_range(0, 3) != 0, $urandom, ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 40)),
                     3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
            if (!req1_valid || a1)
                set1($urandom_range(0, 3) != 0, $urandom, ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 40)),
                     3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
            rsp_ready = $urandom_range(0, 3) != 0;
        end

        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready = 1'b1;
        repeat (4) step();
        check("scoreboard_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
